// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: integer pixel prescaler, h/v counters,
// registered sync/draw/marker decodes and a pixel-tick strobe.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CLK_DIV  = 1,
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned XW      = $clog2(H_TOTAL),
   localparam int unsigned YW      = $clog2(V_TOTAL)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   output logic          pix_tick,
   output logic          hs,
   output logic          vs,
   output logic          draw,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC;

   logic [PW-1:0] r_p;
   logic [PW-1:0] w_p_nxt;
   logic          w_tick;
   logic [XW-1:0] r_x;
   logic [XW-1:0] w_x_nxt;
   logic [YW-1:0] r_y;
   logic [YW-1:0] w_y_nxt;
   logic          w_hs;
   logic          w_vs;
   logic          w_draw;
   logic          w_line_start;
   logic          w_frame_start;

   logic          r_pix_tick;
   logic          r_hs;
   logic          r_vs;
   logic          r_draw;
   logic          r_line_start;
   logic          r_frame_start;

   // Prescaler and raster position advance
   always_comb begin : next_pos
      w_tick  = enable && (r_p == PW'(CLK_DIV - 1));
      w_p_nxt = r_p;
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (enable) begin
         w_p_nxt = w_tick ? '0 : r_p + PW'(1);
      end
      if (w_tick) begin
         if (r_x == XW'(H_TOTAL - 1)) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == YW'(V_TOTAL - 1)) ? '0 : r_y + YW'(1);
         end else begin
            w_x_nxt = r_x + XW'(1);
         end
      end
   end

   // Decodes are taken from the post-update position so they align with x/y
   always_comb begin : decode
      w_hs          = ((32'(w_x_nxt) >= HS_BEG) && (32'(w_x_nxt) < HS_END)) ? H_POL : ~H_POL;
      w_vs          = ((32'(w_y_nxt) >= VS_BEG) && (32'(w_y_nxt) < VS_END)) ? V_POL : ~V_POL;
      w_draw        = (32'(w_x_nxt) < H_ACTIVE) && (32'(w_y_nxt) < V_ACTIVE);
      w_line_start  = (w_x_nxt == '0);
      w_frame_start = (w_x_nxt == '0) && (w_y_nxt == '0);
   end

   // Reset parks the raster on the last pixel of the frame, so the first tick lands on (0,0)
   always_ff @(posedge clock) begin
      if (reset) begin
         r_p           <= '0;
         r_x           <= XW'(H_TOTAL - 1);
         r_y           <= YW'(V_TOTAL - 1);
         r_pix_tick    <= 1'b0;
         r_hs          <= ~H_POL;
         r_vs          <= ~V_POL;
         r_draw        <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_p        <= w_p_nxt;
         r_pix_tick <= w_tick;
         if (w_tick) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_draw        <= w_draw;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
         end
      end
   end

   assign pix_tick    = r_pix_tick;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign draw        = r_draw;
   assign x           = r_x;
   assign y           = r_y;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four parameter sets run side by side, each
// checked every clock against a linear-pixel-index reference model.
module tb_vga_timing_gen;

   localparam int NCFG = 4;
   localparam int NCYC = 2000;
   localparam int C_HA  [NCFG] = '{640, 4, 4, 640};
   localparam int C_HF  [NCFG] = '{16, 1, 1, 16};
   localparam int C_HS  [NCFG] = '{96, 1, 1, 96};
   localparam int C_HB  [NCFG] = '{48, 1, 1, 48};
   localparam int C_VA  [NCFG] = '{480, 3, 3, 480};
   localparam int C_VF  [NCFG] = '{10, 1, 1, 10};
   localparam int C_VS  [NCFG] = '{2, 1, 1, 2};
   localparam int C_VB  [NCFG] = '{33, 1, 1, 33};
   localparam int C_HP  [NCFG] = '{0, 0, 1, 1};
   localparam int C_VP  [NCFG] = '{0, 0, 1, 1};
   localparam int C_DIV [NCFG] = '{1, 3, 1, 1};
   localparam int C_ENP [NCFG] = '{100, 75, 100, 90};  // enable probability, percent
   localparam int C_RSTP[NCFG] = '{0, 8, 0, 2};        // random reset rate, per mille

   typedef struct packed {
      logic        pix;
      logic        hs;
      logic        vs;
      logic        draw;
      logic        ls;
      logic        fs;
      logic [31:0] x;
      logic [31:0] y;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Expected outputs at a linear pixel index (0 = top-left of the visible area)
   function automatic exp_t pixel_at(int g, int lin);
      exp_t e;
      int   ht;
      int   px;
      int   py;
      ht     = C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
      px     = lin % ht;
      py     = lin / ht;
      e.pix  = 1'b1;
      e.hs   = (px >= C_HA[g] + C_HF[g] && px < C_HA[g] + C_HF[g] + C_HS[g]) ? (C_HP[g] != 0) : (C_HP[g] == 0);
      e.vs   = (py >= C_VA[g] + C_VF[g] && py < C_VA[g] + C_VF[g] + C_VS[g]) ? (C_VP[g] != 0) : (C_VP[g] == 0);
      e.draw = (px < C_HA[g]) && (py < C_VA[g]);
      e.ls   = (px == 0);
      e.fs   = (px == 0) && (py == 0);
      e.x    = 32'(px);
      e.y    = 32'(py);
      return e;
   endfunction

   function automatic exp_t reset_state(int g);
      exp_t e;
      e.pix  = 1'b0;
      e.hs   = (C_HP[g] == 0);
      e.vs   = (C_VP[g] == 0);
      e.draw = 1'b0;
      e.ls   = 1'b0;
      e.fs   = 1'b0;
      e.x    = 32'(C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g] - 1);
      e.y    = 32'(C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g] - 1);
      return e;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int unsigned HT = 32'(C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g]);
      localparam int unsigned VT = 32'(C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g]);
      localparam int unsigned XW = $clog2(HT);
      localparam int unsigned YW = $clog2(VT);

      logic          reset;
      logic          enable;
      logic          pix_tick;
      logic          hs;
      logic          vs;
      logic          draw;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          line_start;
      logic          frame_start;
      exp_t          q[$];
      bit            done = 1'b0;
      int            fs_cnt = 0;
      bit            fs_clean = 1'b0;
      bit            fs_prev = 1'b0;

      vga_timing_gen #(
         .H_ACTIVE (32'(C_HA[g])),
         .H_FP     (32'(C_HF[g])),
         .H_SYNC   (32'(C_HS[g])),
         .H_BP     (32'(C_HB[g])),
         .V_ACTIVE (32'(C_VA[g])),
         .V_FP     (32'(C_VF[g])),
         .V_SYNC   (32'(C_VS[g])),
         .V_BP     (32'(C_VB[g])),
         .H_POL    (1'(C_HP[g])),
         .V_POL    (1'(C_VP[g])),
         .CLK_DIV  (32'(C_DIV[g]))
      ) u_dut (
         .clock       (clock),
         .reset       (reset),
         .enable      (enable),
         .pix_tick    (pix_tick),
         .hs          (hs),
         .vs          (vs),
         .draw        (draw),
         .x           (x),
         .y           (y),
         .line_start  (line_start),
         .frame_start (frame_start)
      );

      // Stimulus: position = (enabled clocks since reset) / CLK_DIV pixels past the parked spot
      initial begin : stim
         int   n_en;
         exp_t m;
         n_en = 0;
         m    = reset_state(g);
         for (int c = 0; c < NCYC; c++) begin
            @(negedge clock);
            reset  = (c < 3) || ($urandom_range(999) < 32'(C_RSTP[g]));
            enable = ($urandom_range(99) < 32'(C_ENP[g]));
            if (reset) begin
               n_en = 0;
               m    = reset_state(g);
            end else if (enable) begin
               n_en++;
               if (n_en % C_DIV[g] == 0)
                  m = pixel_at(g, (int'(HT * VT) - 1 + n_en / C_DIV[g]) % int'(HT * VT));
               else
                  m.pix = 1'b0;
            end else begin
               m.pix = 1'b0;
            end
            q.push_back(m);
         end
         @(negedge clock);
         done = 1'b1;
      end

      // Monitor: compare every presented clock of output against the queued expectation
      always @(posedge clock) begin : mon
         exp_t e;
         exp_t a;
         #1;
         if (q.size() > 0) begin
            e      = q.pop_front();
            a.pix  = pix_tick;
            a.hs   = hs;
            a.vs   = vs;
            a.draw = draw;
            a.ls   = line_start;
            a.fs   = frame_start;
            a.x    = 32'(x);
            a.y    = 32'(y);
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL cfg%0d outputs @%0t: got pix=%b hs=%b vs=%b draw=%b ls=%b fs=%b x=%0d y=%0d, want pix=%b hs=%b vs=%b draw=%b ls=%b fs=%b x=%0d y=%0d",
                        g, $time, a.pix, a.hs, a.vs, a.draw, a.ls, a.fs, a.x, a.y,
                        e.pix, e.hs, e.vs, e.draw, e.ls, e.fs, e.x, e.y);
            end
            // Frame period across an interval with enable held high and no reset
            fs_cnt++;
            if (reset || !enable) fs_clean = 1'b0;
            if (frame_start && !fs_prev) begin
               if (fs_clean) begin
                  n_vec++;
                  if (fs_cnt != int'(HT * VT) * C_DIV[g]) begin
                     n_err++;
                     $display("FAIL cfg%0d frame_period: got %0d clocks, want %0d",
                              g, fs_cnt, int'(HT * VT) * C_DIV[g]);
                  end
               end
               fs_cnt   = 0;
               fs_clean = 1'b1;
            end
            fs_prev = frame_start;
         end
      end
   end

   initial begin
      repeat (NCYC + 20) @(posedge clock);
      n_vec++;
      if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) ||
          g_cfg[0].q.size() != 0 || g_cfg[1].q.size() != 0 ||
          g_cfg[2].q.size() != 0 || g_cfg[3].q.size() != 0) begin
         n_err++;
         $display("FAIL completion: stimulus or scoreboard not drained within %0d clocks", NCYC + 20);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
